// File: rtl/nibble_mul_seq.sv
`timescale 1ns/1ps
// nibble_mul_seq: serial 8x8 approximate multiplier. One shared 4x4
// sub-multiplier is issued the four nibble quadrants (LL, LH, HL, HH) in turn
// and the shifted partial products are summed into a wrapping 16-bit result.
// Optional build macro: NIBBLE_MUL_ZERO_SKIP_EN. When defined, a quadrant
// with a zero nibble operand is not issued and completes in one cycle.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | walking quadrants q=0..3 through the sub-multiplier
// DONE  | result presented on out_prod, waiting for out_ready
module nibble_mul_seq #(
  parameter logic [3:0] QMODE   = 4'b1100,
  parameter int         SUB_LAT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_prod,
  output logic        busy,
  output logic        sub_req,
  output logic [3:0]  sub_a,
  output logic [3:0]  sub_b,
  output logic        sub_mode,
  input  logic [7:0]  sub_prod
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [1:0] LAT_LAST = 2'(SUB_LAT);

  state_t      state;
  logic [7:0]  a_r;
  logic [7:0]  b_r;
  logic [15:0] acc;
  logic [1:0]  q;
  logic [1:0]  lat_cnt;
  logic        issued;

  logic [1:0]  ld_q;
  logic [3:0]  ld_a;
  logic [3:0]  ld_b;
  logic        ld_skip;
  logic [15:0] term;
  logic [15:0] acc_sum;
  logic        sample;

  // Operands for the quadrant about to be issued: the first one on entry to
  // RUN, afterwards the one following the quadrant that is completing.
  always_comb begin
    ld_q = issued ? (q + 2'd1) : q;
    ld_a = ld_q[1] ? a_r[7:4] : a_r[3:0];
    ld_b = ld_q[0] ? b_r[7:4] : b_r[3:0];
`ifdef NIBBLE_MUL_ZERO_SKIP_EN
    ld_skip = (ld_a == 4'h0) || (ld_b == 4'h0);
`else
    ld_skip = 1'b0;
`endif
  end

  // Shifted partial product of the current quadrant; a skipped quadrant adds 0.
  always_comb begin
    term = 16'h0000;
    if (sub_req) begin
      case (q)
        2'd0:    term = {8'h00, sub_prod};
        2'd1,
        2'd2:    term = {4'h0, sub_prod, 4'h0};
        default: term = {sub_prod, 8'h00};
      endcase
    end
    acc_sum = acc + term;
    sample  = issued && (!sub_req || (lat_cnt == LAT_LAST));
  end

  // Control FSM with registered handshake and sub-multiplier outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_prod  <= 16'h0000;
      busy      <= 1'b0;
      sub_req   <= 1'b0;
      sub_a     <= 4'h0;
      sub_b     <= 4'h0;
      sub_mode  <= 1'b0;
      a_r       <= 8'h00;
      b_r       <= 8'h00;
      acc       <= 16'h0000;
      q         <= 2'd0;
      lat_cnt   <= 2'd0;
      issued    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid) begin
            a_r      <= in_a;
            b_r      <= in_b;
            acc      <= 16'h0000;
            q        <= 2'd0;
            lat_cnt  <= 2'd0;
            issued   <= 1'b0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          if (!issued || (sample && (q != 2'd3))) begin
            sub_a    <= ld_a;
            sub_b    <= ld_b;
            sub_mode <= QMODE[ld_q];
            sub_req  <= !ld_skip;
            lat_cnt  <= 2'd0;
            issued   <= 1'b1;
            if (issued) begin
              acc <= acc_sum;
              q   <= q + 2'd1;
            end
          end else if (sample) begin
            acc       <= acc_sum;
            out_prod  <= acc_sum;
            out_valid <= 1'b1;
            sub_req   <= 1'b0;
            state     <= DONE;
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_mul_seq.sv
`timescale 1ns/1ps
module tb_nibble_mul_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic out_ready;
  logic const_mode;

  logic in_valid0, in_ready0, out_valid0, busy0, sub_req0, sub_mode0;
  logic [7:0] in_a0, in_b0, sub_prod0;
  logic [3:0] sub_a0, sub_b0;
  logic [15:0] out_prod0;

  logic in_valid2, in_ready2, out_valid2, busy2, sub_req2, sub_mode2;
  logic [7:0] in_a2, in_b2, sub_prod2, pipe1;
  logic [3:0] sub_a2, sub_b2;
  logic [15:0] out_prod2;

  nibble_mul_seq #(.QMODE(4'b1100), .SUB_LAT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_a(in_a0), .in_b(in_b0), .out_valid(out_valid0), .out_ready(out_ready),
    .out_prod(out_prod0), .busy(busy0), .sub_req(sub_req0), .sub_a(sub_a0),
    .sub_b(sub_b0), .sub_mode(sub_mode0), .sub_prod(sub_prod0)
  );

  nibble_mul_seq #(.QMODE(4'b1100), .SUB_LAT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_a(in_a2), .in_b(in_b2), .out_valid(out_valid2), .out_ready(out_ready),
    .out_prod(out_prod2), .busy(busy2), .sub_req(sub_req2), .sub_a(sub_a2),
    .sub_b(sub_b2), .sub_mode(sub_mode2), .sub_prod(sub_prod2)
  );

  // exact (or constant 0xFF) combinational stub for the latency-0 instance
  assign sub_prod0 = const_mode ? 8'hFF : ({4'h0, sub_a0} * {4'h0, sub_b0});

  // exact two-stage pipelined stub for the latency-2 instance
  always_ff @(posedge clk) begin
    pipe1     <= {4'h0, sub_a2} * {4'h0, sub_b2};
    sub_prod2 <= pipe1;
  end

  logic sel;
  logic m_valid, m_req, m_mode, m_ready;
  logic [3:0] m_a, m_b;
  logic [15:0] m_prod;
  assign m_valid = sel ? out_valid2 : out_valid0;
  assign m_ready = sel ? in_ready2  : in_ready0;
  assign m_req   = sel ? sub_req2   : sub_req0;
  assign m_mode  = sel ? sub_mode2  : sub_mode0;
  assign m_a     = sel ? sub_a2     : sub_a0;
  assign m_b     = sel ? sub_b2     : sub_b0;
  assign m_prod  = sel ? out_prod2  : out_prod0;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Issue one operand pair, then follow the transaction until out_valid,
  // recording every cycle in which a quadrant request is driven.
  task automatic txn(input logic s, input logic [7:0] a, input logic [7:0] b,
                     output int lat, output int nreq,
                     output logic [47:0] sa_seq, output logic [47:0] sb_seq,
                     output logic [3:0] mseq);
    sel = s;
    lat = 0; nreq = 0; sa_seq = '0; sb_seq = '0; mseq = '0;
    check("accept_ready", m_ready, 1'b1);
    if (s) begin in_valid2 = 1'b1; in_a2 = a; in_b2 = b; end
    else   begin in_valid0 = 1'b1; in_a0 = a; in_b0 = b; end
    @(posedge clk); #1;
    in_valid0 = 1'b0; in_valid2 = 1'b0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (m_req) begin
        sa_seq = {sa_seq[43:0], m_a};
        sb_seq = {sb_seq[43:0], m_b};
        mseq   = {mseq[2:0], m_mode};
        nreq++;
      end
      if (m_valid) break;
    end
    if (!m_valid) check("timeout_out_valid", m_valid, 1'b1);
  endtask

  int lat, nreq;
  logic [47:0] sa, sb;
  logic [3:0] ms;

  initial begin
    rst_n = 1'b0; out_ready = 1'b1; const_mode = 1'b0; sel = 1'b0;
    in_valid0 = 1'b0; in_a0 = '0; in_b0 = '0;
    in_valid2 = 1'b0; in_a2 = '0; in_b2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state0", {in_ready0, out_valid0, busy0, sub_req0, sub_mode0, sub_a0, sub_b0, out_prod0},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 16'h0000});
    check("reset_state2", {in_ready2, out_valid2, busy2, sub_req2, out_prod2},
          {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000});
    rst_n = 1'b1;
    @(posedge clk); #1;

    // exact stub, latency 0
    txn(1'b0, 8'h5A, 8'h3C, lat, nreq, sa, sb, ms);
    check("exact_5a3c_prod", out_prod0, 16'h1518);
    check("exact_5a3c_lat", lat, 5);
    check("exact_5a3c_modes", ms, 4'b0011);
    check("exact_5a3c_suba", sa, 48'hAA55);
    check("exact_5a3c_subb", sb, 48'hC3C3);
    check("exact_5a3c_busy", busy0, 1'b1);
    @(posedge clk); #1;
    check("post_hs_idle", {out_valid0, in_ready0, busy0, out_prod0}, {1'b0, 1'b1, 1'b0, 16'h1518});

    // constant 0xFF stub, wraps past 16 bits
    const_mode = 1'b1;
    txn(1'b0, 8'hFF, 8'hFF, lat, nreq, sa, sb, ms);
    check("const_ff_wrap", out_prod0, 16'h1FDF);
    @(posedge clk); #1;
    const_mode = 1'b0;

    // latency-2 stub
    txn(1'b1, 8'hFF, 8'hFF, lat, nreq, sa, sb, ms);
    check("lat2_ff_prod", out_prod2, 16'hFE01);
    check("lat2_ff_lat", lat, 13);
    check("lat2_ff_nreq", nreq, 12);
    @(posedge clk); #1;
    txn(1'b1, 8'h5A, 8'h3C, lat, nreq, sa, sb, ms);
    check("lat2_5a3c_prod", out_prod2, 16'h1518);
    check("lat2_5a3c_suba", sa, 48'hAAAAAA555555);
    check("lat2_5a3c_subb", sb, 48'hCCC333CCC333);
    @(posedge clk); #1;

    // backpressure: 0xA7 * 0xB3 = 0x74C5, consumer stalls 10 cycles
    out_ready = 1'b0;
    txn(1'b0, 8'hA7, 8'hB3, lat, nreq, sa, sb, ms);
    check("bp_prod", out_prod0, 16'h74C5);
    in_valid0 = 1'b1; in_a0 = 8'h11; in_b0 = 8'h22;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_hold", {out_valid0, in_ready0, busy0, out_prod0}, {1'b1, 1'b0, 1'b1, 16'h74C5});
    end
    in_valid0 = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release", {out_valid0, in_ready0, busy0, out_prod0}, {1'b0, 1'b1, 1'b0, 16'h74C5});

    // abort during quadrant 2 (HL) of 0x12 * 0x34
    sel = 1'b0;
    in_valid0 = 1'b1; in_a0 = 8'h12; in_b0 = 8'h34;
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_hl_issue", {sub_req0, sub_a0, sub_b0, sub_mode0}, {1'b1, 4'h1, 4'h4, 1'b1});
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_reset_state", {in_ready0, out_valid0, busy0, sub_req0, sub_mode0, sub_a0, sub_b0, out_prod0},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 16'h0000});
    rst_n = 1'b1;
    @(posedge clk); #1;
    txn(1'b0, 8'h02, 8'h03, lat, nreq, sa, sb, ms);
    check("after_abort_prod", out_prod0, 16'h0006);
    @(posedge clk); #1;

`ifdef NIBBLE_MUL_ZERO_SKIP_EN
    txn(1'b0, 8'h50, 8'h03, lat, nreq, sa, sb, ms);
    check("zskip_prod", out_prod0, 16'h00F0);
    check("zskip_lat", lat, 5);
    check("zskip_nreq", nreq, 1);
    check("zskip_hl_ops", {sa[3:0], sb[3:0]}, 8'h53);
    @(posedge clk); #1;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
